priority_encoder_rr: RTL

PRIORITY_ENCODER_RR -- requirements
Module: priority_encoder_rr

---
 rtl/priority_encoder_rr.sv | 110 +++++++++++
 1 files changed

// File: rtl/priority_encoder_rr.sv
// Request accumulator with a registered grant: fixed-priority (highest index wins)
// or round-robin selection over captured requests, handed off through a valid/ready pair.
module priority_encoder_rr #(
    parameter  int N = 4,
    localparam int W = ($clog2(N) > 1) ? $clog2(N) : 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] din,
    input  logic         in_en,
    input  logic         rr_mode,
    input  logic         out_ready,
    output logic [W-1:0] qout,
    output logic         out_valid,
    output logic [N-1:0] pending,
    output logic         idle
);

    logic [N-1:0] pending_q, pending_d;
    logic         out_valid_q, out_valid_d;
    logic [W-1:0] qout_q, qout_d;
    logic [W-1:0] ptr_q, ptr_d;

    logic         load_s;
    logic [W-1:0] fix_idx_s;
    logic [W-1:0] rr_idx_s;
    logic [W-1:0] cand_s;
    logic         rr_found_s;
    logic [W-1:0] grant_s;
    logic [N-1:0] clr_s;

    assign load_s  = (pending_q != {N{1'b0}}) && (!out_valid_q || out_ready);
    assign grant_s = rr_mode ? rr_idx_s : fix_idx_s;

    // Fixed priority: ascending scan, so the highest set index is the last one kept
    always_comb begin
        fix_idx_s = {W{1'b0}};
        for (int i = 0; i < N; i++) begin
            if (pending_q[i]) begin
                fix_idx_s = W'(i);
            end else begin
                fix_idx_s = fix_idx_s;
            end
        end
    end

    // Round-robin: first set bit after ptr, wrapping modulo N (not 2^W)
    always_comb begin
        rr_idx_s   = {W{1'b0}};
        rr_found_s = 1'b0;
        cand_s     = {W{1'b0}};
        for (int k = 1; k <= N; k++) begin
            cand_s = W'((int'(ptr_q) + k) % N);
            if (!rr_found_s && pending_q[cand_s]) begin
                rr_idx_s   = cand_s;
                rr_found_s = 1'b1;
            end else begin
                rr_found_s = rr_found_s;
            end
        end
    end

    // One-hot clear of the bit granted on this edge
    always_comb begin
        clr_s = {N{1'b0}};
        if (load_s) begin
            clr_s[grant_s] = 1'b1;
        end else begin
            clr_s = {N{1'b0}};
        end
    end

    // Next-state: capture is OR-ed in after the clear, so set wins over clear
    always_comb begin
        pending_d   = (pending_q & ~clr_s) | (in_en ? din : {N{1'b0}});
        out_valid_d = out_valid_q;
        qout_d      = qout_q;
        ptr_d       = ptr_q;
        if (load_s) begin
            out_valid_d = 1'b1;
            qout_d      = grant_s;
            ptr_d       = grant_s;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // State registers; ptr resets to N-1 so the first round-robin scan begins at 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q   <= {N{1'b0}};
            out_valid_q <= 1'b0;
            qout_q      <= {W{1'b0}};
            ptr_q       <= W'(N - 1);
        end else begin
            pending_q   <= pending_d;
            out_valid_q <= out_valid_d;
            qout_q      <= qout_d;
            ptr_q       <= ptr_d;
        end
    end

    assign qout      = qout_q;
    assign out_valid = out_valid_q;
    assign pending   = pending_q;
    assign idle      = (pending_q == {N{1'b0}}) && !out_valid_q;

endmodule
